// File: rtl/frame_addr_gen.sv
// Framing-stage read-address sequencer: walks overlapping frames over the sample buffer.
// Optional inter-frame idle gap is enabled with the FRAME_GAP_EN macro.
module frame_addr_gen #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  frame_len_val,
  input  logic [ADDR_WIDTH-1:0] hop_size,
  input  logic [CNT_WIDTH-1:0]  frame_num_val,
  input  logic                  rd_ready,
`ifdef FRAME_GAP_EN
  input  logic [CNT_WIDTH-1:0]  gap_val,
`endif
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  frame_first,
  output logic                  frame_last,
  output logic [CNT_WIDTH-1:0]  frame_idx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
`ifdef FRAME_GAP_EN
    , S_GAP
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, hop_q, hop_d;
  logic [CNT_WIDTH-1:0]  sample_q, sample_d, frame_q, frame_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d, num_q, num_d;
`ifdef FRAME_GAP_EN
  logic [CNT_WIDTH-1:0]  gap_len_q, gap_len_d, gap_cnt_q, gap_cnt_d;
`endif

  logic                  rd_valid_d, frame_first_d, frame_last_d, busy_d, done_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [CNT_WIDTH-1:0]  frame_idx_d;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    hop_d    = hop_q;
    sample_d = sample_q;
    frame_d  = frame_q;
    len_d    = len_q;
    num_d    = num_q;
`ifdef FRAME_GAP_EN
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        len_d    = frame_len_val;
        hop_d    = hop_size;
        num_d    = frame_num_val;
`ifdef FRAME_GAP_EN
        gap_len_d = gap_val;
`endif
        base_d   = '0;
        sample_d = '0;
        frame_d  = '0;
        state_d  = S_RUN;
      end
      S_RUN: if (rd_ready) begin
        if (sample_q != len_q) begin
          sample_d = sample_q + CNT_WIDTH'(1);
        end else if (frame_q != num_q) begin
          sample_d = '0;
          frame_d  = frame_q + CNT_WIDTH'(1);
          base_d   = base_q + hop_q;
`ifdef FRAME_GAP_EN
          gap_cnt_d = '0;
          state_d   = S_GAP;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
`ifdef FRAME_GAP_EN
      // gap_len+1 idle cycles: counter runs 0..gap_len inclusive
      S_GAP: begin
        if (gap_cnt_q == gap_len_q) state_d = S_RUN;
        else gap_cnt_d = gap_cnt_q + CNT_WIDTH'(1);
      end
`endif
      S_DONE: begin
        state_d  = S_IDLE;
        base_d   = '0;
        sample_d = '0;
        frame_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // abort beats any transfer on the same edge; the beat is not delivered
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      base_d   = '0;
      sample_d = '0;
      frame_d  = '0;
    end

    // outputs are registered copies of the next-state view
    rd_valid_d    = (state_d == S_RUN);
    rd_addr_d     = rd_valid_d ? base_d + ADDR_WIDTH'(sample_d) : '0;
    frame_first_d = rd_valid_d && (sample_d == '0);
    frame_last_d  = rd_valid_d && (sample_d == len_d);
    frame_idx_d   = rd_valid_d ? frame_d : '0;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      hop_q       <= '0;
      sample_q    <= '0;
      frame_q     <= '0;
      len_q       <= '0;
      num_q       <= '0;
`ifdef FRAME_GAP_EN
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
`endif
      rd_valid    <= 1'b0;
      rd_addr     <= '0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
      frame_idx   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      hop_q       <= hop_d;
      sample_q    <= sample_d;
      frame_q     <= frame_d;
      len_q       <= len_d;
      num_q       <= num_d;
`ifdef FRAME_GAP_EN
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
`endif
      rd_valid    <= rd_valid_d;
      rd_addr     <= rd_addr_d;
      frame_first <= frame_first_d;
      frame_last  <= frame_last_d;
      frame_idx   <= frame_idx_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_frame_addr_gen.sv
// Bench for frame_addr_gen: expected beat list built from nested frame/sample loops,
// drained against the DUT under fixed, toggling and random rd_ready patterns.
module tb_frame_addr_gen;
  localparam int AW = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, rd_ready;
  logic [CW-1:0] frame_len_val, frame_num_val, gap_val;
  logic [AW-1:0] hop_size;
  logic          rd_valid, frame_first, frame_last, busy, done;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] frame_idx;

  int total = 0;
  int bad   = 0;

  typedef struct { int addr; int first; int last; int idx; } beat_t;
  beat_t q[$];

  frame_addr_gen #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .frame_len_val(frame_len_val), .hop_size(hop_size), .frame_num_val(frame_num_val),
    .rd_ready(rd_ready),
`ifdef FRAME_GAP_EN
    .gap_val(gap_val),
`endif
    .rd_valid(rd_valid), .rd_addr(rd_addr), .frame_first(frame_first),
    .frame_last(frame_last), .frame_idx(frame_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Beat list straight from the framing rules: frame f covers hop*f + 0..len, mod 2^AW.
  task automatic build(input int len, input int num, input int hop);
    q.delete();
    for (int f = 0; f <= num; f++)
      for (int s = 0; s <= len; s++) begin
        beat_t b;
        b.addr = (f * hop + s) % (1 << AW);
        b.first = (s == 0);
        b.last = (s == len);
        b.idx = f;
        q.push_back(b);
      end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
  task automatic run(input int len, input int num, input int hop, input int gap, input int mode);
    int cyc = 0, inv = 0, ph = 0, exp_gap;
    bit rdy;
`ifdef FRAME_GAP_EN
    exp_gap = gap + 1;
`else
    exp_gap = 0;
`endif
    build(len, num, hop);
    @(negedge clk);
    frame_len_val = CW'(len); frame_num_val = CW'(num); hop_size = AW'(hop); gap_val = CW'(gap);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frame_len_val = CW'($urandom); frame_num_val = CW'($urandom); hop_size = AW'($urandom);
    gap_val = CW'($urandom);
    while (q.size() > 0 && cyc < 5000) begin
      if (rd_valid) begin
        if (inv > 0) chk("gap_len", inv, exp_gap);
        inv = 0;
        chk("addr", int'(rd_addr), q[0].addr);
        chk("first", int'(frame_first), q[0].first);
        chk("last", int'(frame_last), q[0].last);
        chk("idx", int'(frame_idx), q[0].idx);
        chk("busy_run", int'(busy), 1);
        case (mode)
          0: rdy = 1'b1;
          1: rdy = (ph % 3 == 0);
          default: rdy = 1'($urandom);
        endcase
        ph++;
        rd_ready = rdy;
        start = 1'($urandom);
        if (rdy) void'(q.pop_front());
      end else begin
        inv++;
        chk("busy_gap", int'(busy), 1);
        chk("done_gap", int'(done), 0);
        rd_ready = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    chk("timeout", q.size(), 0);
    start = 1'b1;
    chk("done_pulse", int'(done), 1);
    chk("done_busy", int'(busy), 1);
    chk("done_valid", int'(rd_valid), 0);
    @(negedge clk);
    start = 1'b0;
    chk("post_done", int'(done), 0);
    chk("post_busy", int'(busy), 0);
    chk("post_valid", int'(rd_valid), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    frame_len_val = '0; frame_num_val = '0; hop_size = '0; gap_val = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", int'({rd_valid, rd_addr, frame_first, frame_last, frame_idx, busy, done}), 0);
    rst = 1'b0;

    run(3, 2, 2, 0, 0);
    run(3, 0, 1, 0, 1);
    run(7, 1, 1020, 0, 2);
    run(0, 0, 5, 0, 0);
    run(2, 3, 0, 1, 2);
    run(1, 2, 9, 3, 1);
    run(1, 1, 2, 2, 0);
    for (int i = 0; i < 6; i++)
      run(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), int'($urandom_range(0, 1023)),
          int'($urandom_range(0, 3)), 2);

    // abort at frame 1 sample 2 (beat 6 of len=3 hop=2) with a simultaneous transfer
    @(negedge clk);
    frame_len_val = 8'd3; frame_num_val = 8'd2; hop_size = 10'd2; gap_val = 8'd0;
    rd_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (rd_valid && frame_idx == 8'd1 && frame_first === 1'b0 && rd_addr == 10'd4) break;
      @(negedge clk);
    end
    chk("abort_pos", int'(rd_addr), 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", int'(rd_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    @(negedge clk);
    chk("abort_done2", int'(done), 0);
    run(3, 2, 2, 0, 0);

    // reset mid-run with start held: everything returns to zero, start ignored
    @(negedge clk);
    frame_len_val = 8'd5; frame_num_val = 8'd3; hop_size = 10'd7; rd_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("run_before_rst", int'(rd_valid), 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_outs", int'({rd_valid, rd_addr, frame_first, frame_last, frame_idx, busy, done}), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_idle_valid", int'(rd_valid), 0);
    chk("rst_idle_busy", int'(busy), 0);
    chk("rst_idle_done", int'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_addr_gen.md
Name: frame_addr_gen

Overview:
- Framing-stage sequencer. Walks overlapping analysis frames over the sample buffer and issues one read address per accepted beat.
- Per-frame sample count and frame count are inclusive terminal values. Counting runs 0..value, and "over" asserts when the count equals the value, the same convention as the loop counters.
- Sits upstream of the windowing/FFT-load path and downstream of the sample buffer.

Parameters:
- ADDR_WIDTH, 10, sample-buffer address width.
- CNT_WIDTH, 8, width of the sample and frame counters and their terminal values.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run. Sampled only in IDLE.
- abort  input  1  synchronous abort. Returns to IDLE, no done pulse.
- frame_len_val  input  CNT_WIDTH  last sample index in a frame (samples per frame = value+1).
- hop_size  input  ADDR_WIDTH  base-address advance between frames.
- frame_num_val  input  CNT_WIDTH  last frame index (frames = value+1).
- rd_ready  input  1  downstream accepts the current beat.
- rd_valid  output  1  rd_addr is valid.
- rd_addr  output  ADDR_WIDTH  base + sample index, modulo 2^ADDR_WIDTH.
- frame_first  output  1  current beat is sample 0 of a frame.
- frame_last  output  1  current beat is the last sample of a frame.
- frame_idx  output  CNT_WIDTH  index of the current frame.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last beat of the last frame is accepted.

Behaviour:
- Reset, sampled on a rising clk edge with rst=1, has priority over all other inputs:
  - state=IDLE.
  - All outputs 0; counters and base address 0.
  - A reset mid-run discards the run: no done, no further beats.
- All outputs are registered.
- FSM states: IDLE, RUN, DONE, plus GAP when the optional feature is enabled.
- IDLE:
  - On start=1, latch frame_len_val, hop_size and frame_num_val into shadow registers; base=0, sample=0, frame=0; go to RUN.
  - Latency: start sampled at edge T gives rd_valid=1, rd_addr=0 after edge T.
  - Config inputs changing after the latch have no effect until the next start.
- RUN:
  - rd_valid=1.
  - A beat transfers on an edge with rd_valid&rd_ready. With rd_ready=0, rd_addr, frame_first, frame_last and frame_idx hold stable.
  - Transfer with sample != len: sample+1.
  - Transfer with sample == len and frame != num: sample=0, frame+1, base=base+hop (ADDR_WIDTH wrap, no saturation).
  - Transfer with sample == len and frame == num: rd_valid drops; go to DONE.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
- frame_first = (sample==0). frame_last = (sample==len). Both are 1 when len=0.
- Degenerate configs:
  - len=0, num=0: a single beat at address 0, then DONE.
  - hop=0: every frame re-reads the same addresses.
  - hop > len+1: gaps between frames are legal.
- start outside IDLE is ignored.
- start in the DONE cycle is ignored. start may be accepted in the IDLE cycle immediately after DONE.
- abort, when rst=0 and the state is not IDLE:
  - next state IDLE; rd_valid=0 from the next cycle; counters cleared; done stays 0.
  - abort takes priority over a simultaneous beat transfer: that beat is counted as not delivered.
- rd_addr computation is (base + zero-extended sample) truncated to ADDR_WIDTH.

Optional Feature:
- Macro FRAME_GAP_EN.
- Defined:
  - Adds input gap_val [CNT_WIDTH-1:0], latched at start.
  - After each non-final frame's last beat, FSM enters GAP with rd_valid=0 and busy=1 for gap_val+1 cycles, then returns to RUN with the new base.
  - No gap after the final frame; DONE follows directly.
  - abort and rst during GAP behave as in RUN.
- Undefined: port and GAP state absent; frames issue back-to-back.

Test Plan:
- len=3, num=2, hop=2, rd_ready=1 → addresses 0,1,2,3,2,3,4,5,4,5,6,7. frame_first on beats 0/4/8, frame_last on beats 3/7/11. done one cycle after beat 11, busy low the following cycle.
- len=3, num=0, hop=1; rd_ready toggling 1,0,0,1,... → rd_addr/flags frozen while stalled; exactly 4 beats; done once.
- ADDR_WIDTH=10, hop=1020, len=7, num=1 → frame 1 addresses 1020..1023,0..3 (wrap).
- Mid-frame abort at frame_idx=1, sample=2 → rd_valid=0 next cycle, no done. New start then restarts at address 0, frame_idx=0.
- rst=1 asserted during RUN together with start=1 → all outputs 0 after the edge, state IDLE; start ignored.
- FRAME_GAP_EN defined, gap_val=2, len=1, num=1, hop=2 → beats 0,1, then 3 cycles of rd_valid=0, then beats 2,3, then done.
